// File: rtl/exec_phase_unit_pkg.sv
// exec_phase_unit_pkg
// Shared constants and helpers for the eight-phase execution unit:
//   - opcode constants of the supported x86 subset
//   - destination load codes consumed by the register file / stack
//   - ALU step enumeration and the combinational ALU function
package exec_phase_unit_pkg;

  // Opcodes (ope[31:24])
  localparam logic [7:0] OP_PUSH_EBP    = 8'h55;
  localparam logic [7:0] OP_POP_EBP     = 8'h5D;
  localparam logic [7:0] OP_MOV_RM_R    = 8'h89;
  localparam logic [7:0] OP_MOV_EAX_IMM = 8'hB8;
  localparam logic [7:0] OP_GRP1_IMM8   = 8'h83;
  localparam logic [7:0] OP_ADD         = 8'h01;

  // ModRM selecting "add esp, imm8" within the 0x83 group
  localparam logic [7:0] MODRM_ADD_ESP  = 8'hC4;

  // Destination load codes; 6..15 are passed through untouched
  localparam logic [3:0] LD_NONE  = 4'd0;
  localparam logic [3:0] LD_EIP   = 4'd1;
  localparam logic [3:0] LD_EBP   = 4'd2;
  localparam logic [3:0] LD_ESP   = 4'd3;
  localparam logic [3:0] LD_STACK = 4'd4;
  localparam logic [3:0] LD_EAX   = 4'd5;

  // Phase count of one instruction
  localparam int NUM_PHASES = 8;

  // Which of the two micro-ops of an instruction is being evaluated
  typedef enum logic {
    STEP_1 = 1'b0,
    STEP_2 = 1'b1
  } step_e;

  // ALU function. ins is ope[31:8]: ins[23:16] opcode, ins[15:8] the
  // ModRM / immediate byte, ins[7:0] the byte after the ModRM.
  // All arithmetic wraps modulo 2^32 with no flags.
  function automatic logic [31:0] alu_func(
    input step_e       step,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [23:0] ins
  );
    logic [7:0]  opcode;
    logic [7:0]  modrm;
    logic [31:0] imm8_sext;
    logic [31:0] res;
    opcode    = ins[23:16];
    modrm     = ins[15:8];
    imm8_sext = {{24{ins[7]}}, ins[7:0]};
    res       = a;
    case (opcode)
      OP_PUSH_EBP:    res = (step == STEP_1) ? (a - 32'd4) : a;
      OP_POP_EBP:     res = (step == STEP_1) ? a : (a + 32'd4);
      OP_MOV_RM_R:    res = a;
      OP_MOV_EAX_IMM: res = {24'd0, modrm};
      OP_GRP1_IMM8:   res = (modrm == MODRM_ADD_ESP) ? (a + imm8_sext) : a;
      OP_ADD:         res = a + b;
      default:        res = a;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/exec_phase_unit_phase_gen.sv
// cpu_phase_gen
// Eight-bit one-hot phase ring. Reset clears the ring to all zeros; the
// first clock after reset release loads phase 1, then it rotates
// 1 -> 2 -> ... -> 8 -> 1 once per clock.
// Ports:
//   clk    in  1  system clock
//   reset  in  1  asynchronous, active-low reset
//   phase  out 8  one-hot phase, bit k-1 = phase k
module cpu_phase_gen (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] phase
);

  logic [7:0] state;
  logic [7:0] next_state;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= 8'h00;
    end else begin
      state <= next_state;
    end
  end

  // Next-state: rotate a legal one-hot value; anything else (including
  // the all-zero reset value) restarts the ring at phase 1.
  always_comb begin
    next_state = 8'h01;
    if ((state != 8'h00) && ((state & (state - 8'h01)) == 8'h00)) begin
      next_state = {state[6:0], state[7]};
    end
  end

  // Output
  always_comb begin
    phase = state;
  end

endmodule

// File: rtl/exec_phase_unit.sv
// exec_phase_unit
// Eight-phase sequencer with execution ALU and destination-code selector.
// Micro-op 1 is captured at the edge ending phase 4, micro-op 2 at the
// edge ending phase 6; the load strobe is cleared at the edges ending
// phases 5 and 7 so it is high for exactly one cycle.
// Ports:
//   clk               in  1   system clock
//   reset             in  1   asynchronous, active-low reset
//   ope               in  32  instruction word (opcode [31:24], ModRM [23:16])
//   operand_a         in  32  selected source register value
//   operand_b         in  32  second operand
//   reg_load_1        in  4   destination code for micro-op 1
//   reg_load_2        in  4   destination code for micro-op 2
//   phase             out 8   one-hot phase
//   alu_result_bus    out 32  registered ALU result
//   selected_reg_load out 4   registered destination strobe (0 = none)
module exec_phase_unit
  import exec_phase_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ope,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [3:0]  reg_load_1,
  input  logic [3:0]  reg_load_2,
  output logic [7:0]  phase,
  output logic [31:0] alu_result_bus,
  output logic [3:0]  selected_reg_load
);

  logic        capture_1;
  logic        capture_2;
  logic        clear_load;
  step_e       step;
  logic [31:0] alu_value;
  logic        unused_ope_low;

  // The byte below the immediate is never consulted by the ALU.
  assign unused_ope_low = ^ope[7:0];

  cpu_phase_gen u_phase_gen (
    .clk   (clk),
    .reset (reset),
    .phase (phase)
  );

  // Phase 4 and 6 edges capture; phase 5 and 7 edges drop the strobe.
  assign capture_1  = phase[3];
  assign capture_2  = phase[5];
  assign clear_load = phase[4] | phase[6];

  always_comb begin
    step      = capture_2 ? STEP_2 : STEP_1;
    alu_value = alu_func(step, operand_a, operand_b, ope[31:8]);
  end

  // Result and strobe registers; untouched outside phases 4-7.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_result_bus    <= 32'd0;
      selected_reg_load <= LD_NONE;
    end else if (capture_1) begin
      alu_result_bus    <= alu_value;
      selected_reg_load <= reg_load_1;
    end else if (capture_2) begin
      alu_result_bus    <= alu_value;
      selected_reg_load <= reg_load_2;
    end else if (clear_load) begin
      selected_reg_load <= LD_NONE;
    end
  end

endmodule

// File: tb/tb_exec_phase_unit.sv
// tb_exec_phase_unit
// Self-checking bench for exec_phase_unit: reset/phase ring sequence,
// directed instruction table, randomized instructions against a
// reference model, and a reset pulse in the middle of an instruction.
module tb_exec_phase_unit;

  logic        clk;
  logic        reset;
  logic [31:0] ope;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [3:0]  reg_load_1;
  logic [3:0]  reg_load_2;
  logic [7:0]  phase;
  logic [31:0] alu_result_bus;
  logic [3:0]  selected_reg_load;

  int tests_run;
  int tests_failed;
  logic [31:0] last_result;

  typedef struct {
    logic [31:0] ope;
    logic [31:0] a1;
    logic [31:0] b1;
    logic [31:0] a2;
    logic [31:0] b2;
    logic [3:0]  rl1;
    logic [3:0]  rl2;
    logic [31:0] exp_r1;
    logic [31:0] exp_r2;
  } vec_t;

  vec_t vecs[8];

  exec_phase_unit dut (
    .clk               (clk),
    .reset             (reset),
    .ope               (ope),
    .operand_a         (operand_a),
    .operand_b         (operand_b),
    .reg_load_1        (reg_load_1),
    .reg_load_2        (reg_load_2),
    .phase             (phase),
    .alu_result_bus    (alu_result_bus),
    .selected_reg_load (selected_reg_load)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour of one micro-op, written from the instruction
  // semantics: step is 1 or 2.
  function automatic logic [31:0] ref_alu(input logic [31:0] instr, input int step,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [7:0] op;
    logic [7:0] modrm;
    int signed  imm;
    op    = instr[31:24];
    modrm = instr[23:16];
    imm   = $signed(instr[15:8]);
    if (op == 8'h55) return (step == 1) ? a - 32'd4 : a;
    if (op == 8'h5D) return (step == 1) ? a : a + 32'd4;
    if (op == 8'hB8) return 32'(modrm);
    if (op == 8'h83 && modrm == 8'hC4) return a + 32'(imm);
    if (op == 8'h01) return a + b;
    return a;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Wait (at falling edges) until the ring shows phase 4; bounded.
  task automatic waitPhase4(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (phase === 8'h08) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL wait_phase4: phase %h never reached 08", phase);
    end
  endtask

  // Run one full instruction from phase 4 to phase 8 and check both
  // micro-ops, the strobe shape and the hold behaviour.
  task automatic applyStimulus(input vec_t v, input string tag);
    bit ok;
    waitPhase4(ok);
    if (!ok) return;
    checkOutput({tag, " hold_result_p4"}, alu_result_bus, last_result);
    checkOutput({tag, " hold_load_p4"}, 32'(selected_reg_load), 32'd0);
    ope = v.ope; operand_a = v.a1; operand_b = v.b1;
    reg_load_1 = v.rl1; reg_load_2 = v.rl2;
    @(negedge clk);
    checkOutput({tag, " phase5"}, 32'(phase), 32'h10);
    checkOutput({tag, " result1"}, alu_result_bus, v.exp_r1);
    checkOutput({tag, " load1"}, 32'(selected_reg_load), 32'(v.rl1));
    operand_a = v.a2; operand_b = v.b2;
    @(negedge clk);
    checkOutput({tag, " result1_p6"}, alu_result_bus, v.exp_r1);
    checkOutput({tag, " load_p6"}, 32'(selected_reg_load), 32'd0);
    @(negedge clk);
    checkOutput({tag, " result2"}, alu_result_bus, v.exp_r2);
    checkOutput({tag, " load2"}, 32'(selected_reg_load), 32'(v.rl2));
    @(negedge clk);
    checkOutput({tag, " result2_p8"}, alu_result_bus, v.exp_r2);
    checkOutput({tag, " load_p8"}, 32'(selected_reg_load), 32'd0);
    last_result = v.exp_r2;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    last_result  = 32'd0;
    reset      = 1'b0;
    ope        = 32'd0;
    operand_a  = 32'd0;
    operand_b  = 32'd0;
    reg_load_1 = 4'd0;
    reg_load_2 = 4'd0;

    //            ope           a1            b1     a2            b2     rl1 rl2 r1            r2
    vecs[0] = '{32'h55000000, 32'h00001000, 32'd0, 32'h0000ABCD, 32'd0, 4'd3, 4'd4, 32'h00000FFC, 32'h0000ABCD};
    vecs[1] = '{32'h83C4F800, 32'h00001000, 32'd0, 32'h00001000, 32'd0, 4'd3, 4'd3, 32'h00000FF8, 32'h00000FF8};
    vecs[2] = '{32'h83C41000, 32'h00001000, 32'd0, 32'h00001000, 32'd0, 4'd3, 4'd3, 32'h00001010, 32'h00001010};
    vecs[3] = '{32'hB8020000, 32'h00001234, 32'd7, 32'h00005678, 32'd9, 4'd5, 4'd5, 32'h00000002, 32'h00000002};
    vecs[4] = '{32'h01000000, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd1, 4'd5, 4'd5, 32'h00000000, 32'h00000000};
    vecs[5] = '{32'h5D000000, 32'hFFFFFFFC, 32'd0, 32'hFFFFFFFC, 32'd0, 4'd2, 4'd3, 32'hFFFFFFFC, 32'h00000000};
    vecs[6] = '{32'h83C0F800, 32'h00000055, 32'd0, 32'h00000066, 32'd0, 4'd15, 4'd6, 32'h00000055, 32'h00000066};
    vecs[7] = '{32'h89000000, 32'h00000011, 32'd3, 32'h00000022, 32'd4, 4'd1, 4'd1, 32'h00000011, 32'h00000022};

    // Reset state
    @(negedge clk);
    checkOutput("reset_phase", 32'(phase), 32'h0);
    checkOutput("reset_result", alu_result_bus, 32'h0);
    checkOutput("reset_load", 32'(selected_reg_load), 32'h0);

    // Release and follow the ring for nine edges
    reset = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      checkOutput($sformatf("ring_phase_%0d", i), 32'(phase), 32'(1) << (i % 8));
      checkOutput($sformatf("ring_result_%0d", i), alu_result_bus, 32'h0);
      checkOutput($sformatf("ring_load_%0d", i), 32'(selected_reg_load), 32'h0);
    end

    // Directed table
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Randomized instructions against the reference model
    for (int i = 0; i < 40; i++) begin
      vec_t v;
      logic [7:0] op;
      logic [7:0] modrm;
      case ($urandom_range(0, 6))
        0: op = 8'h55;
        1: op = 8'h5D;
        2: op = 8'h89;
        3: op = 8'hB8;
        4: op = 8'h83;
        5: op = 8'h01;
        default: op = 8'($urandom);
      endcase
      modrm = ($urandom_range(0, 1) == 0) ? 8'hC4 : 8'($urandom);
      v.ope = {op, modrm, 16'($urandom)};
      v.a1  = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF - 32'($urandom_range(0, 8)) : $urandom;
      v.b1  = $urandom;
      v.a2  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
      v.b2  = $urandom;
      v.rl1 = 4'($urandom);
      v.rl2 = 4'($urandom);
      v.exp_r1 = ref_alu(v.ope, 1, v.a1, v.b1);
      v.exp_r2 = ref_alu(v.ope, 2, v.a2, v.b2);
      applyStimulus(v, $sformatf("rnd%0d", i));
    end

    // Reset pulsed during phase 5 of a push
    begin
      bit ok;
      waitPhase4(ok);
      if (ok) begin
        ope = 32'h55000000; operand_a = 32'h00002000; operand_b = 32'd0;
        reg_load_1 = 4'd3; reg_load_2 = 4'd4;
        @(negedge clk);
        checkOutput("mid_pre_result", alu_result_bus, 32'h00001FFC);
        checkOutput("mid_pre_load", 32'(selected_reg_load), 32'd3);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("mid_async_phase", 32'(phase), 32'h0);
        checkOutput("mid_async_result", alu_result_bus, 32'h0);
        checkOutput("mid_async_load", 32'(selected_reg_load), 32'h0);
        ope = 32'd0; operand_a = 32'd0; reg_load_1 = 4'd0; reg_load_2 = 4'd0;
        @(negedge clk);
        checkOutput("mid_held_phase", 32'(phase), 32'h0);
        checkOutput("mid_held_result", alu_result_bus, 32'h0);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          checkOutput($sformatf("restart_phase_%0d", i), 32'(phase), 32'(1) << i);
          checkOutput($sformatf("restart_load_%0d", i), 32'(selected_reg_load), 32'h0);
          checkOutput($sformatf("restart_result_%0d", i), alu_result_bus, 32'h0);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
